// File: rtl/nav_pkg.sv
// ============================================================================
//  Module      : nav_pkg
//  Description : Shared navigation encodings: motor commands, orientation
//                direction codes, bad-angle marker and the heading-aligner
//                state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nav_pkg;

  // Motor driver command encoding (11 is never driven)
  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  // Orientation stage direction encoding
  localparam logic [1:0] DIR_ZERO = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  // Orientation stage reports unusable data with an all-ones angle
  localparam logic [7:0] ANGLE_BAD = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_TURN    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_SAMPLE  = 3'd4,
    ST_FIN_OK  = 3'd5,
    ST_FIN_ERR = 3'd6
  } align_state_e;

  // Pass counter saturates instead of wrapping so a stuck request never
  // reports a small pass count.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/align_timer.sv
// ============================================================================
//  Module      : align_timer
//  Description : Loadable down-counter shared by the turn and settle phases.
//                expire_o is high for the single cycle the count sits at 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module align_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expire_o = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/heading_aligner.sv
// ============================================================================
//  Module      : heading_aligner
//  Description : Rotates the robot in place to null the reported heading
//                angle. Turns for ANGLE*TICKS_PER_DEG cycles, lets the
//                sensors settle, re-samples and repeats until aligned or the
//                pass limit is reached. START/ABORT/DONE/FAULT handshake
//                towards the navigation FSM, motor commands to the driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heading_aligner
  import nav_pkg::*;
#(
  parameter int unsigned TICKS_PER_DEG = 32'd50000,
  parameter int unsigned SETTLE_TICKS  = 32'd2500000,
  parameter int unsigned DEADBAND      = 32'd2,
  parameter int unsigned MAX_PASSES    = 32'd4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] ANGLE,
  input  logic [1:0] DIRECTION,
  output logic [1:0] MOTOR_L,
  output logic [1:0] MOTOR_R,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAULT,
  output logic [2:0] PASS_CNT
);

  align_state_e state_q, state_d;
  logic [7:0]   angle_q, angle_d;
  logic [1:0]   dir_q,   dir_d;
  logic [2:0]   pass_q,  pass_d;
  logic [1:0]   motl_q,  motl_d;
  logic [1:0]   motr_q,  motr_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;
  logic         fault_q, fault_d;

  logic         tmr_load;
  logic [31:0]  tmr_value;
  logic         tmr_expire;
  logic [31:0]  turn_ticks;

  // Zero-extended product; parameters are chosen so 255*TICKS_PER_DEG fits.
  assign turn_ticks = 32'(angle_q) * TICKS_PER_DEG;

  align_timer #(
    .WIDTH (32)
  ) u_timer (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  // State register plus registered copies of every output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      angle_q <= '0;
      dir_q   <= DIR_ZERO;
      pass_q  <= '0;
      motl_q  <= MOT_STOP;
      motr_q  <= MOT_STOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      dir_q   <= dir_d;
      pass_q  <= pass_d;
      motl_q  <= motl_d;
      motr_q  <= motr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they are
  // valid in the same cycle the state is entered.
  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    dir_d     = dir_q;
    pass_d    = pass_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          angle_d = ANGLE;
          dir_d   = DIRECTION;
          pass_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dir_q == DIR_BAD || angle_q == ANGLE_BAD) begin
          state_d = ST_FIN_ERR;
        end else if (dir_q == DIR_ZERO || angle_q <= 8'(DEADBAND)) begin
          state_d = ST_FIN_OK;
        end else if (pass_q == 3'(MAX_PASSES)) begin
          state_d = ST_FIN_ERR;
        end else begin
          tmr_load  = 1'b1;
          tmr_value = turn_ticks;
          state_d   = ST_TURN;
        end
      end
      ST_TURN: begin
        if (tmr_expire) begin
          pass_d    = sat_inc3(pass_q);
          tmr_load  = 1'b1;
          tmr_value = SETTLE_TICKS;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        angle_d = ANGLE;
        dir_d   = DIRECTION;
        state_d = ST_CHECK;
      end
      ST_FIN_OK:  state_d = ST_IDLE;
      ST_FIN_ERR: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Abort overrides everything outside IDLE; pass count is kept so the
    // navigation FSM can see how far the request got.
    if (ABORT && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      angle_d   = angle_q;
      dir_d     = dir_q;
      pass_d    = pass_q;
      tmr_load  = 1'b1;
      tmr_value = '0;
    end

    motl_d = MOT_STOP;
    motr_d = MOT_STOP;
    if (state_d == ST_TURN) begin
      if (dir_q == DIR_POS) begin
        motl_d = MOT_REV;
        motr_d = MOT_FWD;
      end else if (dir_q == DIR_NEG) begin
        motl_d = MOT_FWD;
        motr_d = MOT_REV;
      end
    end
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN_OK);
    fault_d = (state_d == ST_FIN_ERR);
  end

  assign MOTOR_L  = motl_q;
  assign MOTOR_R  = motr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign FAULT    = fault_q;
  assign PASS_CNT = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_heading_aligner.sv
// ============================================================================
//  Module      : tb_heading_aligner
//  Description : Self-checking bench for heading_aligner. A schedule-based
//                model expands each decision into the list of per-cycle
//                outputs it implies; directed requests add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_heading_aligner;

  localparam int TPD  = 4;
  localparam int STK  = 3;
  localparam int DB   = 2;
  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] angle = 8'd0;
  logic [1:0] dir = 2'b00;
  logic [1:0] mot_l, mot_r;
  logic       busy, done, fault;
  logic [2:0] pass_cnt;

  int checks = 0;
  int errors = 0;

  heading_aligner #(
    .TICKS_PER_DEG (TPD),
    .SETTLE_TICKS  (STK),
    .DEADBAND      (DB),
    .MAX_PASSES    (MAXP)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .ABORT     (abort),
    .ANGLE     (angle),
    .DIRECTION (dir),
    .MOTOR_L   (mot_l),
    .MOTOR_R   (mot_r),
    .BUSY      (busy),
    .DONE      (done),
    .FAULT     (fault),
    .PASS_CNT  (pass_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: a queue of per-cycle outputs -------
  typedef struct packed {
    logic [1:0] ml;
    logic [1:0] mr;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] pass;
  } out_t;

  out_t q[$];
  out_t exp_o = '0;
  bit   resample = 0;
  int   mpass = 0;

  function automatic out_t mk(input logic [1:0] ml, input logic [1:0] mr,
                              input logic b, input logic dn, input logic f,
                              input int p);
    out_t o;
    o.ml = ml; o.mr = mr; o.busy = b; o.done = dn; o.fault = f; o.pass = 3'(p);
    return o;
  endfunction

  // Expand one evaluation of (angle, direction, passes) into the outputs of
  // every following cycle up to the next decision point.
  task automatic plan(input logic [7:0] a, input logic [1:0] d, input int p);
    int n;
    int pn;
    q.push_back(mk(2'b00, 2'b00, 1, 0, 0, p));               // evaluation cycle
    if (d == 2'b11 || a == 8'hFF) begin
      q.push_back(mk(2'b00, 2'b00, 1, 0, 1, p));
    end else if (d == 2'b00 || int'(a) <= DB) begin
      q.push_back(mk(2'b00, 2'b00, 1, 1, 0, p));
    end else if (p == MAXP) begin
      q.push_back(mk(2'b00, 2'b00, 1, 0, 1, p));
    end else begin
      n  = int'(a) * TPD;
      pn = (p == 7) ? 7 : p + 1;
      for (int i = 0; i < n; i++)
        q.push_back(d == 2'b01 ? mk(2'b10, 2'b01, 1, 0, 0, p)
                               : mk(2'b01, 2'b10, 1, 0, 0, p));
      for (int i = 0; i < STK; i++)
        q.push_back(mk(2'b00, 2'b00, 1, 0, 0, pn));
      q.push_back(mk(2'b00, 2'b00, 1, 0, 0, pn));            // re-sample cycle
      resample = 1;
      mpass    = pn;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        resample = 0;
        exp_o    = '0;
      end else if (exp_o.busy && abort) begin
        q.delete();
        resample = 0;
        exp_o    = mk(2'b00, 2'b00, 0, 0, 0, int'(exp_o.pass));
      end else begin
        if (q.size() == 0 && resample) begin
          resample = 0;
          plan(angle, dir, mpass);
        end else if (q.size() == 0 && !exp_o.busy && start) begin
          plan(angle, dir, 0);
        end
        if (q.size() != 0) exp_o = q.pop_front();
        else               exp_o = mk(2'b00, 2'b00, 0, 0, 0, int'(exp_o.pass));
      end
    end
  end

  // ---------------- per-cycle compare against the model --------------------
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ({mot_l, mot_r, busy, done, fault, pass_cnt} !== exp_o ||
          mot_l == 2'b11 || mot_r == 2'b11 ||
          (mot_l == mot_r && mot_l != 2'b00)) begin
        errors++;
        $display("FAIL cycle t=%0t got L=%b R=%b B=%b D=%b F=%b P=%0d expected L=%b R=%b B=%b D=%b F=%b P=%0d",
                 $time, mot_l, mot_r, busy, done, fault, pass_cnt,
                 exp_o.ml, exp_o.mr, exp_o.busy, exp_o.done, exp_o.fault, exp_o.pass);
      end
    end
  end

  // ---------------- literal checks ------------------------------------------
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  int r_turn, r_ccw, r_cw, r_done_at, r_fault_at, r_nd, r_nf, r_end;

  // One request; cycle k=1 is the cycle after the START edge.
  task automatic do_req(input logic [7:0] a, input logic [1:0] d,
                        input int chg_at, input logic [7:0] a2, input logic [1:0] d2,
                        input int start_at, input int abort_at);
    r_turn = 0; r_ccw = 0; r_cw = 0; r_done_at = 0; r_fault_at = 0;
    r_nd = 0; r_nf = 0; r_end = 0;
    @(negedge clk);
    angle = a; dir = d; start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == start_at);
      abort = (k == abort_at);
      if (k == chg_at) begin angle = a2; dir = d2; end
      if (mot_l != 2'b00 || mot_r != 2'b00) r_turn++;
      if (mot_l == 2'b10 && mot_r == 2'b01) r_ccw++;
      if (mot_l == 2'b01 && mot_r == 2'b10) r_cw++;
      if (done)  begin r_nd++; r_done_at = k; end
      if (fault) begin r_nf++; r_fault_at = k; end
      if (!busy) begin r_end = k; break; end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", int'({mot_l, mot_r, busy, done, fault, pass_cnt}), 0);

    // 10 deg positive, target reached after one pass
    do_req(8'd10, 2'b01, 43, 8'd0, 2'b00, 0, 0);
    chk("t1_ccw_cycles", r_ccw, 40);
    chk("t1_turn_cycles", r_turn, 40);
    chk("t1_done_at", r_done_at, 47);
    chk("t1_end", r_end, 48);
    chk("t1_pass", int'(pass_cnt), 1);
    chk("t1_faults", r_nf, 0);

    // 5 deg negative, with an ignored START while busy
    do_req(8'd5, 2'b10, 23, 8'd0, 2'b00, 10, 0);
    chk("t2_cw_cycles", r_cw, 20);
    chk("t2_turn_cycles", r_turn, 20);
    chk("t2_done_at", r_done_at, 27);
    chk("t2_done_count", r_nd, 1);
    chk("t2_pass", int'(pass_cnt), 1);

    // inside deadband
    do_req(8'd2, 2'b01, 0, 8'd0, 2'b00, 0, 0);
    chk("t3_done_at", r_done_at, 2);
    chk("t3_turn_cycles", r_turn, 0);
    chk("t3_pass", int'(pass_cnt), 0);

    // bad data
    do_req(8'hFF, 2'b01, 0, 8'd0, 2'b00, 0, 0);
    chk("t4a_fault_at", r_fault_at, 2);
    chk("t4a_turn_cycles", r_turn, 0);
    do_req(8'd10, 2'b11, 0, 8'd0, 2'b00, 0, 0);
    chk("t4b_fault_at", r_fault_at, 2);
    chk("t4b_done_count", r_nd, 0);

    // never converges
    do_req(8'd10, 2'b01, 0, 8'd0, 2'b00, 0, 0);
    chk("t5_ccw_cycles", r_ccw, 160);
    chk("t5_fault_at", r_fault_at, 182);
    chk("t5_done_count", r_nd, 0);
    chk("t5_pass", int'(pass_cnt), 4);

    // abort in turn cycle 15 of the first pass
    do_req(8'd10, 2'b01, 0, 8'd0, 2'b00, 0, 16);
    chk("t6_turn_cycles", r_turn, 15);
    chk("t6_end", r_end, 17);
    chk("t6_pulses", r_nd + r_nf, 0);
    chk("t6_pass", int'(pass_cnt), 0);

    // abort in turn cycle 15 of the second pass: pass count held at 1
    do_req(8'd10, 2'b01, 0, 8'd0, 2'b00, 0, 61);
    chk("t7_turn_cycles", r_turn, 55);
    chk("t7_end", r_end, 62);
    chk("t7_pass", int'(pass_cnt), 1);

    // asynchronous reset mid-turn
    @(negedge clk);
    angle = 8'd10; dir = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t8_turning_before_reset", int'({mot_l, mot_r}), 4'b1001);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_async_reset_outputs", int'({mot_l, mot_r, busy, done, fault, pass_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // recovery after reset
    do_req(8'd1, 2'b10, 0, 8'd0, 2'b00, 0, 0);
    chk("t9_done_at", r_done_at, 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
